// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words, writes them to program memory,
// and verifies an 8-bit additive checksum. One write cycle follows each completed word.
module prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wa,
  output logic [15:0]           wd,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_CHK, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]   MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE_N = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_cnt_hi;
  logic [7:0]            r_hi;
  logic [7:0]            r_sum;
  logic [ADDR_WIDTH:0]   r_n;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH:0]   r_words;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_wa;
  logic [15:0]           r_wd;

  logic                  w_accept;
  logic [15:0]           w_hdr;
  logic [ADDR_WIDTH:0]   w_clamp;
  logic                  w_last;

  assign w_accept = in_valid && in_ready;
  assign w_hdr    = {r_cnt_hi, in_data};
  // Counts beyond the memory depth load the full memory once.
  assign w_clamp  = ({16'h0000, w_hdr} > 32'(MAX_N)) ? MAX_N : (ADDR_WIDTH+1)'(w_hdr);
  assign w_last   = (({1'b0, r_idx} + ONE_N) == r_n);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)    w_next = S_HDR_HI;
      S_HDR_HI: if (w_accept) w_next = S_HDR_LO;
      S_HDR_LO: if (w_accept) w_next = (w_clamp == '0) ? S_CHK : S_DAT_HI;
      S_DAT_HI: if (w_accept) w_next = S_DAT_LO;
      S_DAT_LO: if (w_accept) w_next = S_WRITE;
      S_WRITE:  w_next = w_last ? S_CHK : S_DAT_HI;
      S_CHK:    if (w_accept) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    we       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO, S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        we   = 1'b1;
        busy = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_hi <= '0;
      r_hi     <= '0;
      r_sum    <= '0;
      r_n      <= '0;
      r_idx    <= '0;
      r_words  <= '0;
      r_err    <= 1'b0;
      r_wa     <= '0;
      r_wd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_err   <= 1'b0;
          r_words <= '0;
          r_sum   <= '0;
          r_idx   <= '0;
        end
        S_HDR_HI: if (w_accept) begin
          r_cnt_hi <= in_data;
          r_sum    <= r_sum + in_data;
        end
        S_HDR_LO: if (w_accept) begin
          r_n   <= w_clamp;
          r_sum <= r_sum + in_data;
        end
        S_DAT_HI: if (w_accept) begin
          r_hi  <= in_data;
          r_sum <= r_sum + in_data;
        end
        // Address and data are registered here so they are stable for the whole write cycle.
        S_DAT_LO: if (w_accept) begin
          r_wd  <= {r_hi, in_data};
          r_wa  <= BASE + r_idx;
          r_sum <= r_sum + in_data;
        end
        S_WRITE: begin
          r_idx   <= r_idx + ONE_A;
          r_words <= r_words + ONE_N;
        end
        S_CHK: if (w_accept) r_err <= (in_data != r_sum);
        default: ;
      endcase
    end
  end

  assign wa           = r_wa;
  assign wd           = r_wd;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0 and base 1022) share one byte stream; writes are
// checked against a scoreboard queue per instance, loads are driven from a vector table.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, in_valid;
  logic [7:0] in_data;

  logic        rdy0, we0, busy0, done0, err0;
  logic [9:0]  wa0;
  logic [15:0] wd0;
  logic [10:0] wl0;
  logic        rdy1, we1, busy1, done1, err1;
  logic [9:0]  wa1;
  logic [15:0] wd1;
  logic [10:0] wl1;

  prog_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .we(we0), .wa(wa0), .wd(wd0), .busy(busy0), .done(done0),
    .err(err0), .words_loaded(wl0)
  );

  prog_loader #(.ADDR_WIDTH(10), .BASE_ADDR(1022)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .we(we1), .wa(wa1), .wd(wd1), .busy(busy1), .done(done1),
    .err(err1), .words_loaded(wl1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [9:0]  wa;
    logic [15:0] wd;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  wr_t e0, e1;
  int  done_cnt0 = 0;
  int  done_cnt1 = 0;

  always @(negedge clk) begin
    if (we0) begin
      if (q0.size() == 0) check("unexpected_we0", {31'd0, we0}, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("wa0", {22'd0, wa0}, {22'd0, e0.wa});
        check("wd0", {16'd0, wd0}, {16'd0, e0.wd});
      end
      check("in_ready_in_write0", {31'd0, rdy0}, 32'd0);
    end
    if (we1) begin
      if (q1.size() == 0) check("unexpected_we1", {31'd0, we1}, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("wa1", {22'd0, wa1}, {22'd0, e1.wa});
        check("wd1", {16'd0, wd1}, {16'd0, e1.wd});
      end
    end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  bit         stall_mode = 0;
  bit         start_mode = 0;
  logic [7:0] sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit add);
    int guard = 0;
    bit acc = 0;
    in_data = b;
    while (!acc) begin
      in_valid = !(stall_mode && ($urandom_range(0, 2) == 0));
      start    = start_mode && ($urandom_range(0, 3) == 0);
      acc      = in_valid && rdy0;
      tick();
      guard++;
      if (!acc && guard > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL byte_timeout: in_ready never seen for byte %0h", b);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (add) sum = sum + b;
  endtask

  task automatic push_word(input int i, input logic [15:0] w);
    wr_t e;
    e.wd = w;
    e.wa = 10'(i);
    q0.push_back(e);
    e.wa = 10'(1022 + i);
    q1.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] hdr, input int nw, input logic [15:0] fw0,
                         input logic [15:0] fw1, input bit bad);
    logic [15:0] w;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy0}, 32'd1);
    check("err_cleared_by_start", {31'd0, err0}, 32'd0);
    check("words_cleared_by_start", {21'd0, wl0}, 32'd0);
    sum = 8'h00;
    send_byte(hdr[15:8], 1);
    send_byte(hdr[7:0], 1);
    for (int i = 0; i < nw; i++) begin
      w = (i == 0) ? fw0 : (i == 1) ? fw1 : 16'($urandom);
      push_word(i, w);
      send_byte(w[15:8], 1);
      send_byte(w[7:0], 1);
    end
    send_byte(bad ? sum + 8'h01 : sum, 0);
    check("done_in_done_state", {31'd0, done0}, 32'd1);
    check("busy_low_in_done", {31'd0, busy0}, 32'd0);
    check("in_ready_low_in_done", {31'd0, rdy0}, 32'd0);
    tick();
    check("done_single_cycle", {31'd0, done0}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] hdr;
    int          nw;
    logic [15:0] w0;
    logic [15:0] w1;
    bit          bad;
    bit          stall;
    bit          xstart;
    bit          exp_err;
    int          exp_words;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{16'h0002, 2,    16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vt[1] = '{16'h0002, 2,    16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b1, 2};
    vt[2] = '{16'h0000, 0,    16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[3] = '{16'h0002, 2,    16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    vt[4] = '{16'h0003, 3,    16'h0F0F, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vt[5] = '{16'h0FFF, 1024, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1024};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check("rst_in_ready", {31'd0, rdy0}, 32'd0);
    check("rst_we", {31'd0, we0}, 32'd0);
    check("rst_wa", {22'd0, wa0}, 32'd0);
    check("rst_wd", {16'd0, wd0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_err", {31'd0, err0}, 32'd0);
    check("rst_words", {21'd0, wl0}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("idle_in_ready", {31'd0, rdy0}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      stall_mode = vt[v].stall;
      start_mode = vt[v].xstart;
      done_cnt0 = 0;
      done_cnt1 = 0;
      do_load(vt[v].hdr, vt[v].nw, vt[v].w0, vt[v].w1, vt[v].bad);
      check("done_pulses0", done_cnt0, 1);
      check("done_pulses1", done_cnt1, 1);
      check("err0", {31'd0, err0}, {31'd0, vt[v].exp_err});
      check("err1", {31'd0, err1}, {31'd0, vt[v].exp_err});
      check("words_loaded0", {21'd0, wl0}, vt[v].exp_words);
      check("words_loaded1", {21'd0, wl1}, vt[v].exp_words);
      check("sb_empty0", q0.size(), 0);
      check("sb_empty1", q1.size(), 0);
      tick(); tick(); tick();
      check("err_sticky_idle", {31'd0, err0}, {31'd0, vt[v].exp_err});
      check("words_hold_idle", {21'd0, wl0}, vt[v].exp_words);
    end
    stall_mode = 0;
    start_mode = 0;

    // Start with a byte offered in IDLE: the byte must not be taken.
    start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    check("idle_start_no_accept", {31'd0, rdy0}, 32'd0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("busy_rises", {31'd0, busy0}, 32'd1);
    sum = 8'h00;
    send_byte(8'h00, 1);
    send_byte(8'h05, 1);
    push_word(0, 16'h1111); send_byte(8'h11, 1); send_byte(8'h11, 1);
    push_word(1, 16'h2222); send_byte(8'h22, 1); send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    tick();
    check("wa_before_reset", {22'd0, wa0}, 32'd1);
    // Reset lands mid-cycle while the low byte of word 3 is awaited.
    #2 reset = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, rdy0}, 32'd0);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_we", {31'd0, we0}, 32'd0);
    check("midrst_err", {31'd0, err0}, 32'd0);
    check("midrst_wa", {22'd0, wa0}, 32'd0);
    check("midrst_words", {21'd0, wl0}, 32'd0);
    check("sb_empty_at_reset", q0.size(), 0);
    tick();
    reset = 1'b0;
    tick();
    done_cnt0 = 0;
    do_load(16'h0002, 2, 16'h5A5A, 16'hC3C3, 1'b0);
    check("after_rst_done", done_cnt0, 1);
    check("after_rst_words", {21'd0, wl0}, 32'd2);
    check("after_rst_err", {31'd0, err0}, 32'd0);
    check("after_rst_sb_empty", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
